pipelined_regfile_two_stage: RTL and testbench



---
 rtl/pipelined_regfile_two_stage.sv | 116 +++++++++++
 tb/tb_pipelined_regfile_two_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_regfile_two_stage.sv
// pipelined_regfile_two_stage
//   Two-stage pipeline demonstrator. IF/ID fetches from one of two ROM images
//   and reads the register file, and EXE/WB runs the ALU and writes back.
//   Every stage value is exported so that a bench can observe it.
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   fileid             ROM image select (0 = A, 1 = B), combinational
//   PCOUT, INST        current PC and the instruction it addresses
//   aluop, rdata1/2    decode-stage op and register read ports
//   *_ID_EXE           ID/EXE pipeline register contents
//   aluout             EXE-stage ALU result, written back on the next edge
module pipelined_regfile_two_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        fileid,
    output logic [15:0] PCOUT,
    output logic [15:0] INST,
    output logic [2:0]  aluop,
    output logic [15:0] rdata1,
    output logic [15:0] rdata2,
    output logic [15:0] rdata1_ID_EXE,
    output logic [15:0] rdata2_ID_EXE,
    output logic [2:0]  aluop_ID_EXE,
    output logic [3:0]  waddr_out_ID_EXE,
    output logic [15:0] aluout
);
    logic [15:0] pc_q, pc_d;
    logic [15:0] rf_q [16];
    logic [15:0] rdata1_q, rdata2_q, rdata1_d, rdata2_d;
    logic [2:0]  aluop_q, aluop_d;
    logic [3:0]  waddr_q, waddr_d;
    logic [15:0] inst_w, alu_w;
    logic [3:0]  rs1, rs2;

    // Instruction ROMs. Only the low 8 PC bits index them, so they alias every 256.
    always_comb begin
        inst_w = '0;
        if (fileid) begin
            case (pc_q[7:0])
                8'h00:   inst_w = 16'h61F1;
                8'h01:   inst_w = 16'h7212;
                default: inst_w = '0;
            endcase
        end else begin
            case (pc_q[7:0])
                8'h00:   inst_w = 16'h0312;
                8'h01:   inst_w = 16'h1434;
                8'h02:   inst_w = 16'h2556;
                8'h03:   inst_w = 16'h3678;
                default: inst_w = '0;
            endcase
        end
    end

    assign rs1     = inst_w[7:4];
    assign rs2     = inst_w[3:0];
    assign aluop_d = inst_w[14:12];
    assign waddr_d = inst_w[11:8];
    assign pc_d    = pc_q + 16'd1;

    // EXE-stage ALU.
    always_comb begin
        alu_w = '0;
        case (aluop_q)
            3'd0: alu_w = rdata1_q + rdata2_q;
            3'd1: alu_w = rdata1_q - rdata2_q;
            3'd2: alu_w = rdata1_q & rdata2_q;
            3'd3: alu_w = rdata1_q | rdata2_q;
            3'd4: alu_w = rdata1_q ^ rdata2_q;
            3'd5: alu_w = ~rdata1_q;
            3'd6: alu_w = rdata1_q << rdata2_q[3:0];
            3'd7: alu_w = rdata1_q >> rdata2_q[3:0];
            default: alu_w = '0;
        endcase
    end

    // Read ports. The instruction in EXE has not been written back yet, so
    // its result is forwarded to any read of the same register. That removes
    // the need for a stall on back-to-back dependencies. r0 is hard-wired to
    // zero, which also stops forwarding from a NOP destination.
    always_comb begin
        rdata1_d = '0;
        rdata2_d = '0;
        if (rs1 != 4'd0) rdata1_d = (rs1 == waddr_q) ? alu_w : rf_q[rs1];
        if (rs2 != 4'd0) rdata2_d = (rs2 == waddr_q) ? alu_w : rf_q[rs2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            aluop_q  <= '0;
            waddr_q  <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= 16'(i);
        end else begin
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            aluop_q  <= aluop_d;
            waddr_q  <= waddr_d;
            if (waddr_q != 4'd0) rf_q[waddr_q] <= alu_w;
        end
    end

    assign PCOUT            = pc_q;
    assign INST             = inst_w;
    assign aluop            = aluop_d;
    assign rdata1           = rdata1_d;
    assign rdata2           = rdata2_d;
    assign rdata1_ID_EXE    = rdata1_q;
    assign rdata2_ID_EXE    = rdata2_q;
    assign aluop_ID_EXE     = aluop_q;
    assign waddr_out_ID_EXE = waddr_q;
    assign aluout           = alu_w;
endmodule

// File: tb/tb_pipelined_regfile_two_stage.sv
// Scoreboard bench for pipelined_regfile_two_stage. The reference model is
// architectural: each instruction commits completely when it leaves IF/ID.
// The expected pipeline-port values are taken from that committed state.
module tb_pipelined_regfile_two_stage;
    logic        clk = 0, rst = 0, fileid = 0;
    logic [15:0] PCOUT, INST, rdata1, rdata2, rdata1_ID_EXE, rdata2_ID_EXE, aluout;
    logic [2:0]  aluop, aluop_ID_EXE;
    logic [3:0]  waddr_out_ID_EXE;

    pipelined_regfile_two_stage dut (
        .clk(clk), .rst(rst), .fileid(fileid), .PCOUT(PCOUT), .INST(INST),
        .aluop(aluop), .rdata1(rdata1), .rdata2(rdata2),
        .rdata1_ID_EXE(rdata1_ID_EXE), .rdata2_ID_EXE(rdata2_ID_EXE),
        .aluop_ID_EXE(aluop_ID_EXE), .waddr_out_ID_EXE(waddr_out_ID_EXE),
        .aluout(aluout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc, inst, rd1, rd2, rd1e, rd2e, alu;
        logic [2:0]  op, ope;
        logic [3:0]  wa;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0;

    // Architectural model state.
    logic [15:0] arch [16];
    logic [15:0] m_pc;
    logic [15:0] last_a, last_b, last_res;
    logic [2:0]  last_op;
    logic [3:0]  last_rd;

    function automatic logic [15:0] rom(input logic f, input logic [15:0] pc);
        int idx = int'(pc) % 256;
        if (f) return (idx == 0) ? 16'h61F1 : (idx == 1) ? 16'h7212 : 16'h0000;
        case (idx)
            0: return 16'h0312;
            1: return 16'h1434;
            2: return 16'h2556;
            3: return 16'h3678;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int sh = int'(b) % 16;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) arch[i] = 16'(i);
        arch[0] = 0;
        m_pc = 0; last_a = 0; last_b = 0; last_res = 0; last_op = 0; last_rd = 0;
    endtask

    task automatic model_step();
        logic [15:0] ins;
        ins      = rom(fileid, m_pc);
        last_op  = ins[14:12];
        last_rd  = ins[11:8];
        last_a   = arch[ins[7:4]];
        last_b   = arch[ins[3:0]];
        last_res = alu(last_op, last_a, last_b);
        if (last_rd != 0) arch[last_rd] = last_res;
        m_pc = m_pc + 16'd1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Drive inputs mid-cycle and queue the expected port values.
    task automatic drive(input logic r, input logic f);
        exp_t e;
        logic [15:0] ins;
        @(negedge clk);
        rst = r; fileid = f;
        if (r) model_reset();
        #1;
        ins = rom(fileid, m_pc);
        e.pc = m_pc; e.inst = ins; e.op = ins[14:12];
        e.rd1 = arch[ins[7:4]]; e.rd2 = arch[ins[3:0]];
        e.rd1e = last_a; e.rd2e = last_b; e.ope = last_op; e.wa = last_rd; e.alu = last_res;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
    endtask

    task automatic cyc(input logic r, input logic f);
        drive(r, f);
        step();
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("PCOUT", PCOUT, e.pc);
                chk("INST", INST, e.inst);
                chk("aluop", {13'd0, aluop}, {13'd0, e.op});
                chk("rdata1", rdata1, e.rd1);
                chk("rdata2", rdata2, e.rd2);
                chk("rdata1_ID_EXE", rdata1_ID_EXE, e.rd1e);
                chk("rdata2_ID_EXE", rdata2_ID_EXE, e.rd2e);
                chk("aluop_ID_EXE", {13'd0, aluop_ID_EXE}, {13'd0, e.ope});
                chk("waddr_ID_EXE", {12'd0, waddr_out_ID_EXE}, {12'd0, e.wa});
                chk("aluout", aluout, e.alu);
            end
        end
    end

    logic [15:0] seq_alu [1:5];
    logic [15:0] seq_wa  [1:5];
    int          rst_left;
    logic        f_r;

    initial begin
        seq_alu = '{16'h0003, 16'hFFFF, 16'h0004, 16'h000F, 16'h0000};
        seq_wa  = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd0};
        model_reset();
        #1 rst = 1;

        // Reset held across edges.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0);
            chk("rst PCOUT", PCOUT, 16'h0000);
            chk("rst aluout", aluout, 16'h0000);
            chk("rst waddr", {12'd0, waddr_out_ID_EXE}, 16'h0000);
            step();
        end

        // Image A from reset.
        drive(0, 0);
        chk("A PCOUT0 INST", INST, 16'h0312);
        step();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0);
            chk("A PCOUT", PCOUT, 16'(k));
            chk("A aluout", aluout, seq_alu[k]);
            chk("A waddr", {12'd0, waddr_out_ID_EXE}, seq_wa[k]);
            if (k == 1) chk("A bypass rdata1", rdata1, 16'h0003);
            step();
        end

        // Asynchronous reset mid-run.
        drive(1, 1);
        chk("midrst PCOUT", PCOUT, 16'h0000);
        chk("midrst aluout", aluout, 16'h0000);
        chk("midrst waddr", {12'd0, waddr_out_ID_EXE}, 16'h0000);
        step();
        cyc(1, 1);

        // Image B from reset.
        drive(0, 1);
        step();
        drive(0, 1);
        chk("B PCOUT1 aluout", aluout, 16'h001E);
        step();
        drive(0, 1);
        chk("B PCOUT2 aluout", aluout, 16'h0007);
        step();

        // Randomised image switching and reset pulses.
        rst_left = 0;
        f_r = 0;
        for (int k = 0; k < 1500; k++) begin
            if (rst_left == 0 && $urandom_range(0, 63) == 0) rst_left = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) f_r = ~f_r;
            cyc(rst_left != 0, f_r);
            if (rst_left != 0) rst_left--;
        end

        // PC wrap after 65536 cycles.
        cyc(1, 0);
        drive(0, 0);
        step();
        for (int k = 0; k < 65535; k++) cyc(0, 0);
        drive(0, 0);
        chk("wrap PCOUT", PCOUT, 16'h0000);
        chk("wrap INST", INST, 16'h0312);
        step();

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
